// File: rtl/rv32i_control_pkg.sv
// Shared definitions for the friscv fetch/decode/control unit and its ALU queue.
// Latency: n/a (constants, types and a pure decode helper only).
// Backpressure: n/a.
package friscv_h;

  // RV32I base opcodes (inst[6:0])
  localparam logic [6:0] NOP_OP  = 7'b0000000;
  localparam logic [6:0] LUI     = 7'b0110111;
  localparam logic [6:0] AUIPC   = 7'b0010111;
  localparam logic [6:0] JAL     = 7'b1101111;
  localparam logic [6:0] JALR    = 7'b1100111;
  localparam logic [6:0] BRANCH  = 7'b1100011;
  localparam logic [6:0] LOAD    = 7'b0000011;
  localparam logic [6:0] STORE   = 7'b0100011;
  localparam logic [6:0] I_ARITH = 7'b0010011;
  localparam logic [6:0] R_ARITH = 7'b0110011;
  localparam logic [6:0] FENCE   = 7'b0001111;
  localparam logic [6:0] SYS     = 7'b1110011;

  // Branch conditions (funct3)
  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  localparam int ALU_FIFO_DEPTH = 4;

  // ALU instruction bus: {opcode, funct3, funct7, rs1, rs2, rd, imm12, imm20}, opcode at the MSBs
  localparam int ALU_INSTBUS_W = 64;
  localparam int IMM20_LSB  = 0;
  localparam int IMM12_LSB  = 20;
  localparam int RD_LSB     = 32;
  localparam int RS2_LSB    = 37;
  localparam int RS1_LSB    = 42;
  localparam int FUNCT7_LSB = 47;
  localparam int FUNCT3_LSB = 54;
  localparam int OPCODE_LSB = 57;

  typedef enum logic {
    CTRL_BOOT,
    CTRL_RUN
  } ctrl_state_t;

  // How the control unit treats an opcode
  typedef enum logic [1:0] {
    CLS_ILLEGAL,
    CLS_ALU,     // queued to the ALU
    CLS_FLOW,    // executed locally, needs an empty ALU queue
    CLS_NOP      // only advances the PC
  } inst_class_t;

  function automatic inst_class_t classify(input logic [6:0] op);
    inst_class_t cls;
    case (op)
      LUI, LOAD, STORE, I_ARITH, R_ARITH, SYS: cls = CLS_ALU;
      AUIPC, JAL, JALR, BRANCH:                cls = CLS_FLOW;
      NOP_OP, FENCE:                           cls = CLS_NOP;
      default:                                 cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/rv32i_control_fifo.sv
// Synchronous single-clock FIFO with full/empty flags; head is shown on data_out.
// Latency: a pushed word is visible at data_out the cycle after the push edge.
// Backpressure: pushes while full and pops while empty are ignored.
module friscv_scfifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             srst,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign data_out = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; storage itself needs no reset
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (srst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + AW'(1);
      if (do_push && !do_pop)
        count <= count + (AW+1)'(1);
      else if (do_pop && !do_push)
        count <= count - (AW+1)'(1);
    end
  end

  // Storage write
  always_ff @(posedge aclk) begin
    if (do_push)
      mem[wr_ptr] <= data_in;
  end

endmodule

// File: rtl/rv32i_control.sv
// RV32I fetch/decode/control: runs AUIPC/JAL/JALR/branches locally, queues ALU-class ops.
// Latency: accepted instruction updates pc/rd outputs on the accept edge; ALU ops reach alu_instbus one cycle later.
// Backpressure: fetch stalls (inst_en low) while the ALU queue is full; flow ops wait for the queue to drain.
module rv32i_control
  import friscv_h::*;
#(
  parameter int ADDRW     = 16,
  parameter int BOOT_ADDR = 0,
  parameter int XLEN      = 32
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     srst,
  output logic                     inst_en,
  output logic [ADDRW-1:0]         inst_addr,
  input  logic [XLEN-1:0]          inst_rdata,
  input  logic                     inst_ready,
  output logic                     alu_en,
  input  logic                     alu_ready,
  output logic [ALU_INSTBUS_W-1:0] alu_instbus,
  output logic [4:0]               ctrl_rs1_addr,
  input  logic [XLEN-1:0]          ctrl_rs1_val,
  output logic [4:0]               ctrl_rs2_addr,
  input  logic [XLEN-1:0]          ctrl_rs2_val,
  output logic                     ctrl_rd_wr,
  output logic [4:0]               ctrl_rd_addr,
  output logic [XLEN-1:0]          ctrl_rd_val
);

  ctrl_state_t state_q, state_d;
  logic        run;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next;
  logic            rd_wr_next;
  logic [4:0]      rd_addr_next;
  logic [XLEN-1:0] rd_val_next;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  inst_class_t iclass;
  logic        inst_error;
  logic        cond;
  logic        accept;
  logic        alu_inst_wr;
  logic        alu_pop;
  logic        taken;

  logic                     fifo_full;
  logic                     fifo_empty;
  logic [ALU_INSTBUS_W-1:0] alu_wdata;

  logic [XLEN-1:0] imm_u, imm_j, imm_i, imm_b;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] jalr_sum;

  assign opcode        = inst_rdata[6:0];
  assign funct3        = inst_rdata[14:12];
  assign ctrl_rs1_addr = inst_rdata[19:15];
  assign ctrl_rs2_addr = inst_rdata[24:20];
  assign inst_addr     = pc[ADDRW-1:0];

  assign iclass     = classify(opcode);
  assign inst_error = (iclass == CLS_ILLEGAL);
  assign run        = (state_q == CTRL_RUN);
  assign inst_en    = run & ~fifo_full;
  assign alu_en     = ~fifo_empty;
  assign alu_pop    = alu_en & alu_ready;

  // Immediates, sign-extended to XLEN
  assign imm_u = XLEN'($signed({inst_rdata[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({inst_rdata[31], inst_rdata[19:12], inst_rdata[20],
                                inst_rdata[30:21], 1'b0}));
  assign imm_i = XLEN'($signed(inst_rdata[31:20]));
  assign imm_b = XLEN'($signed({inst_rdata[31], inst_rdata[7], inst_rdata[30:25],
                                inst_rdata[11:8], 1'b0}));

  assign pc_plus4 = pc + XLEN'(4);
  assign jalr_sum = ctrl_rs1_val + imm_i;

  // Per-class acceptance condition: ALU ops need room, flow ops need a drained queue
  always_comb begin
    cond = 1'b0;
    case (iclass)
      CLS_ALU:  cond = ~fifo_full;
      CLS_FLOW: cond = fifo_empty;
      CLS_NOP:  cond = 1'b1;
      default:  cond = 1'b0;
    endcase
  end

  assign accept      = inst_en & inst_ready & ~inst_error & cond;
  assign alu_inst_wr = accept & (iclass == CLS_ALU);

  // Branch comparison on the operands present in the accept cycle
  always_comb begin
    taken = 1'b0;
    case (funct3)
      BEQ:     taken = (ctrl_rs1_val == ctrl_rs2_val);
      BNE:     taken = (ctrl_rs1_val != ctrl_rs2_val);
      BLT:     taken = ($signed(ctrl_rs1_val) <  $signed(ctrl_rs2_val));
      BGE:     taken = ($signed(ctrl_rs1_val) >= $signed(ctrl_rs2_val));
      BLTU:    taken = (ctrl_rs1_val <  ctrl_rs2_val);
      BGEU:    taken = (ctrl_rs1_val >= ctrl_rs2_val);
      default: taken = 1'b0;
    endcase
  end

  // Pack the decoded fields for the ALU queue
  always_comb begin
    alu_wdata = '0;
    alu_wdata[OPCODE_LSB +: 7]  = inst_rdata[6:0];
    alu_wdata[FUNCT3_LSB +: 3]  = inst_rdata[14:12];
    alu_wdata[FUNCT7_LSB +: 7]  = inst_rdata[31:25];
    alu_wdata[RS1_LSB    +: 5]  = inst_rdata[19:15];
    alu_wdata[RS2_LSB    +: 5]  = inst_rdata[24:20];
    alu_wdata[RD_LSB     +: 5]  = inst_rdata[11:7];
    alu_wdata[IMM12_LSB  +: 12] = inst_rdata[31:20];
    alu_wdata[IMM20_LSB  +: 20] = inst_rdata[31:12];
  end

  // Next PC and rd write-back for the accepted instruction
  always_comb begin
    pc_next      = pc;
    rd_wr_next   = 1'b0;
    rd_addr_next = ctrl_rd_addr;
    rd_val_next  = ctrl_rd_val;
    if (accept) begin
      case (iclass)
        CLS_ALU, CLS_NOP: pc_next = pc_plus4;
        CLS_FLOW: begin
          case (opcode)
            AUIPC: begin
              pc_next      = pc + imm_u;
              rd_wr_next   = 1'b1;
              rd_addr_next = inst_rdata[11:7];
              rd_val_next  = pc + imm_u;
            end
            JAL: begin
              pc_next      = pc + imm_j;
              rd_wr_next   = 1'b1;
              rd_addr_next = inst_rdata[11:7];
              rd_val_next  = pc_plus4;
            end
            JALR: begin
              pc_next      = {jalr_sum[XLEN-1:1], 1'b0};
              rd_wr_next   = 1'b1;
              rd_addr_next = inst_rdata[11:7];
              rd_val_next  = pc_plus4;
            end
            default: pc_next = taken ? (pc + imm_b) : pc_plus4;
          endcase
        end
        default: pc_next = pc;
      endcase
    end
  end

  // Boot sequencing: fetch starts one cycle after reset release
  always_comb begin
    state_d = state_q;
    case (state_q)
      CTRL_BOOT: state_d = CTRL_RUN;
      CTRL_RUN:  state_d = CTRL_RUN;
      default:   state_d = CTRL_BOOT;
    endcase
  end

  // State, PC and rd registers
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q      <= CTRL_BOOT;
      pc           <= XLEN'(BOOT_ADDR);
      ctrl_rd_wr   <= 1'b0;
      ctrl_rd_addr <= '0;
      ctrl_rd_val  <= '0;
    end else if (srst) begin
      state_q      <= CTRL_BOOT;
      pc           <= XLEN'(BOOT_ADDR);
      ctrl_rd_wr   <= 1'b0;
      ctrl_rd_addr <= '0;
      ctrl_rd_val  <= '0;
    end else begin
      state_q      <= state_d;
      pc           <= pc_next;
      ctrl_rd_wr   <= rd_wr_next;
      ctrl_rd_addr <= rd_addr_next;
      ctrl_rd_val  <= rd_val_next;
    end
  end

  friscv_scfifo #(
    .WIDTH (ALU_INSTBUS_W),
    .DEPTH (ALU_FIFO_DEPTH)
  ) u_alu_fifo (
    .aclk     (aclk),
    .areset   (areset),
    .srst     (srst),
    .push     (alu_inst_wr),
    .data_in  (alu_wdata),
    .pop      (alu_pop),
    .data_out (alu_instbus),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_rv32i_control.sv
// Self-checking bench for rv32i_control: directed steps then random traffic against a behavioural model.
module tb_rv32i_control;

  logic        aclk = 1'b0;
  logic        areset;
  logic        srst;
  logic        inst_en;
  logic [15:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_ready;
  logic        alu_en;
  logic        alu_ready;
  logic [63:0] alu_instbus;
  logic [4:0]  ctrl_rs1_addr;
  logic [31:0] ctrl_rs1_val;
  logic [4:0]  ctrl_rs2_addr;
  logic [31:0] ctrl_rs2_val;
  logic        ctrl_rd_wr;
  logic [4:0]  ctrl_rd_addr;
  logic [31:0] ctrl_rd_val;

  always #5 aclk = ~aclk;

  rv32i_control dut (
    .aclk          (aclk),
    .areset        (areset),
    .srst          (srst),
    .inst_en       (inst_en),
    .inst_addr     (inst_addr),
    .inst_rdata    (inst_rdata),
    .inst_ready    (inst_ready),
    .alu_en        (alu_en),
    .alu_ready     (alu_ready),
    .alu_instbus   (alu_instbus),
    .ctrl_rs1_addr (ctrl_rs1_addr),
    .ctrl_rs1_val  (ctrl_rs1_val),
    .ctrl_rs2_addr (ctrl_rs2_addr),
    .ctrl_rs2_val  (ctrl_rs2_val),
    .ctrl_rd_wr    (ctrl_rd_wr),
    .ctrl_rd_addr  (ctrl_rd_addr),
    .ctrl_rd_val   (ctrl_rd_val)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_pc;
  bit          m_run;
  logic [63:0] m_q[$];
  bit          m_rd_wr;
  logic [4:0]  m_rd_addr;
  logic [31:0] m_rd_val;

  localparam logic [6:0] OPS [12] = '{7'h00, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63,
                                      7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // 0 illegal, 1 queued to ALU, 2 jump/branch/auipc, 3 nop/fence
  function automatic int kind_of(input logic [6:0] op);
    if (op inside {7'h37, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73}) return 1;
    if (op inside {7'h17, 7'h6F, 7'h67, 7'h63}) return 2;
    if (op inside {7'h00, 7'h0F}) return 3;
    return 0;
  endfunction

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [24:0] hi);
    return {hi, op};
  endfunction

  task automatic model_reset();
    m_pc = 32'd0; m_run = 0; m_q.delete();
    m_rd_wr = 0; m_rd_addr = 5'd0; m_rd_val = 32'd0;
  endtask

  // Registered outputs, sampled at the falling edge
  task automatic check_regs();
    chk("inst_en", 64'(inst_en), 64'(m_run && m_q.size() < 4));
    chk("inst_addr", 64'(inst_addr), 64'(m_pc[15:0]));
    chk("alu_en", 64'(alu_en), 64'(m_q.size() != 0));
    if (m_q.size() != 0) chk("alu_instbus", alu_instbus, m_q[0]);
    chk("rd_wr", 64'(ctrl_rd_wr), 64'(m_rd_wr));
    chk("rd_addr", 64'(ctrl_rd_addr), 64'(m_rd_addr));
    chk("rd_val", 64'(ctrl_rd_val), 64'(m_rd_val));
  endtask

  // One clock: drive at the falling edge, check decode, advance model across the rising edge
  task automatic cycle(input logic [31:0] inst, input bit rdy, input bit ardy,
                       input logic [31:0] a, input logic [31:0] b, input bit sr);
    int  kind;
    bit  full, empty, acc, taken;
    int  off;
    logic [31:0] t;
    inst_rdata = inst; inst_ready = rdy; alu_ready = ardy;
    ctrl_rs1_val = a; ctrl_rs2_val = b; srst = sr;
    #1;
    kind  = kind_of(inst[6:0]);
    full  = (m_q.size() == 4);
    empty = (m_q.size() == 0);
    acc   = m_run && !full && rdy &&
            ((kind == 1) || (kind == 2 && empty) || (kind == 3));
    chk("inst_error", 64'(dut.inst_error), 64'(kind == 0));
    chk("alu_inst_wr", 64'(dut.alu_inst_wr), 64'(acc && kind == 1));
    chk("rs1_addr", 64'(ctrl_rs1_addr), 64'(inst[19:15]));
    chk("rs2_addr", 64'(ctrl_rs2_addr), 64'(inst[24:20]));
    @(posedge aclk);
    if (sr) model_reset();
    else begin
      if (ardy && m_q.size() > 0) void'(m_q.pop_front());
      m_rd_wr = 0;
      if (acc) begin
        case (inst[6:0])
          7'h17: begin
            m_pc = m_pc + {inst[31:12], 12'h000};
            m_rd_wr = 1; m_rd_addr = inst[11:7]; m_rd_val = m_pc;
          end
          7'h6F: begin
            off = int'({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0});
            if (inst[31]) off = off - (1 << 21);
            m_rd_wr = 1; m_rd_addr = inst[11:7]; m_rd_val = m_pc + 32'd4;
            m_pc = m_pc + 32'(off);
          end
          7'h67: begin
            off = int'(inst[31:20]);
            if (inst[31]) off = off - 4096;
            t = a + 32'(off);
            t[0] = 1'b0;
            m_rd_wr = 1; m_rd_addr = inst[11:7]; m_rd_val = m_pc + 32'd4;
            m_pc = t;
          end
          7'h63: begin
            off = int'({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0});
            if (inst[31]) off = off - 8192;
            case (inst[14:12])
              3'd0: taken = (a == b);
              3'd1: taken = (a != b);
              3'd4: taken = (int'(a) <  int'(b));
              3'd5: taken = (int'(a) >= int'(b));
              3'd6: taken = (a <  b);
              3'd7: taken = (a >= b);
              default: taken = 0;
            endcase
            m_pc = taken ? m_pc + 32'(off) : m_pc + 32'd4;
          end
          default: begin
            if (kind == 1)
              m_q.push_back({inst[6:0], inst[14:12], inst[31:25], inst[19:15],
                             inst[24:20], inst[11:7], inst[31:20], inst[31:12]});
            m_pc = m_pc + 32'd4;
          end
        endcase
      end
      m_run = 1;
    end
    @(negedge aclk);
    check_regs();
  endtask

  logic [31:0] ri, ra, rb;

  initial begin
    areset = 1'b1; srst = 1'b0; inst_rdata = '0; inst_ready = 1'b0;
    alu_ready = 1'b0; ctrl_rs1_val = '0; ctrl_rs2_val = '0;
    model_reset();
    repeat (2) @(negedge aclk);
    check_regs();
    areset = 1'b0;
    cycle(32'h0, 0, 0, 0, 0, 0);

    // Decode of every legal opcode (not handshaken), then illegal ones offered
    for (int i = 0; i < 12; i++) cycle(mk(OPS[i], 25'h0), 0, 0, 0, 0, 0);
    cycle(mk(7'b0000001, 25'h0), 1, 0, 0, 0, 0);
    cycle(mk(7'b0101001, 25'h0), 1, 0, 0, 0, 0);
    cycle(mk(7'b1111111, 25'h0), 1, 0, 0, 0, 0);

    // ALU queue streaming, then fill with alu_ready low, then drain
    cycle(mk(7'h03, 25'h0123), 1, 1, 0, 0, 0);
    cycle(mk(7'h37, 25'h1ABCD), 1, 1, 0, 0, 0);
    cycle(mk(7'h23, 25'h0F0F0), 1, 1, 0, 0, 0);
    cycle(mk(7'h13, 25'h15555), 1, 1, 0, 0, 0);
    cycle(mk(7'h33, 25'h0AAAA), 1, 1, 0, 0, 0);
    cycle(mk(7'h73, 25'h00001), 1, 1, 0, 0, 0);
    repeat (2) cycle(32'h0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(mk(7'h73, 25'(i * 7 + 1)), 1, 0, 0, 0, 0);
    chk("inst_en_full", 64'(inst_en), 64'd0);
    cycle(mk(7'h6F, 25'h0), 1, 0, 0, 0, 0);
    repeat (5) cycle(mk(7'h6F, 25'h0), 0, 1, 0, 0, 0);

    // AUIPC from pc 0
    cycle(32'h0, 0, 0, 0, 0, 1);
    cycle(32'h0, 0, 0, 0, 0, 0);
    cycle(32'h0000_0017, 1, 0, 0, 0, 0);
    cycle(32'h0000_1017, 1, 0, 0, 0, 0);
    cycle(32'h0000_1197, 1, 0, 0, 0, 0);
    cycle(32'hFFFF_FC17, 1, 0, 0, 0, 0);
    chk("auipc_wrap_pc", 64'(inst_addr), 64'h1000);

    // JAL and JALR from pc 0
    cycle(32'h0, 0, 0, 0, 0, 1);
    cycle(32'h0, 0, 0, 0, 0, 0);
    cycle(32'h0000_01EF, 1, 0, 0, 0, 0);
    cycle(32'h0010_02EF, 1, 0, 0, 0, 0);
    chk("jal_bit20_pc", 64'(inst_addr), 64'h800);
    cycle(32'h0, 0, 0, 0, 0, 1);
    cycle(32'h0, 0, 0, 0, 0, 0);
    cycle(32'h0010_0067, 1, 0, 0, 0, 0);
    cycle(32'h0020_0167, 1, 0, 0, 0, 0);

    // Branches from pc 0 with offset 16, mixing taken and not taken
    cycle(32'h0, 0, 0, 0, 0, 1);
    cycle(32'h0, 0, 0, 0, 0, 0);
    cycle(32'h0000_0863, 1, 0, 32'h5, 32'h5, 0);
    cycle(32'h0000_1863, 1, 0, 32'h5, 32'h5, 0);
    cycle(32'h0000_1863, 1, 0, 32'h5, 32'h6, 0);
    cycle(32'h0000_4863, 1, 0, 32'hFFFF_FFFF, 32'h00FF_FFFF, 0);
    cycle(32'h0000_5863, 1, 0, 32'h1234, 32'h1234, 0);
    cycle(32'h0000_6863, 1, 0, 32'hFFFF_FFFF, 32'h00FF_FFFF, 0);
    cycle(32'h0000_6863, 1, 0, 32'h1, 32'h00FF_FFFF, 0);
    cycle(32'h0000_7863, 1, 0, 32'h0FFF_FFFF, 32'h00FF_FFFF, 0);
    cycle(32'h0000_7863, 1, 0, 32'h00FF_FFF0, 32'h00FF_FFFF, 0);
    cycle(32'h0000_2863, 1, 0, 32'h1, 32'h1, 0);
    cycle(32'h8000_0FE3, 1, 0, 32'h1, 32'h1, 0);

    // Random traffic with occasional synchronous resets and one asynchronous reset
    for (int n = 0; n < 1500; n++) begin
      ri = $urandom;
      if ($urandom_range(0, 15) != 0) ri[6:0] = OPS[$urandom_range(0, 11)];
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : 32'($urandom);
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 16));
      cycle(ri, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, ra, rb,
            $urandom_range(0, 99) == 0);
      if (n == 750) begin
        #2 areset = 1'b1;
        #1;
        chk("arst_inst_en", 64'(inst_en), 64'd0);
        chk("arst_pc", 64'(inst_addr), 64'd0);
        chk("arst_alu_en", 64'(alu_en), 64'd0);
        chk("arst_rd_wr", 64'(ctrl_rd_wr), 64'd0);
        chk("arst_rd_val", 64'(ctrl_rd_val), 64'd0);
        model_reset();
        @(negedge aclk);
        areset = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
